// File: rtl/fib_pkg.sv
// Shared types and constants for the binary/Fibonacci codec: FSM state encoding,
// a constant Fibonacci function and the default start weights of the weight walker.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // fib(0)=0, fib(1)=1, fib(2)=1, fib(3)=2, ...
  function automatic logic [63:0] fib(input int n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Highest digit k=fib_w-1 carries F(fib_w+1); its partner is F(fib_w+2).
  function automatic logic [63:0] fib_top(input int fib_w);
    return fib(fib_w + 1);
  endfunction

  function automatic logic [63:0] fib_next(input int fib_w);
    return fib(fib_w + 2);
  endfunction

  localparam int          FIB_W_DEF = 24;
  localparam logic [63:0] FIB_TOP   = fib_top(FIB_W_DEF);
  localparam logic [63:0] FIB_NEXT  = fib_next(FIB_W_DEF);

endpackage

// File: rtl/binary_fibonacci_codec_if.sv
// Request/result bundle of the binary/Fibonacci codec, plus a debug view of the FSM state.
interface binary_fibonacci_codec_if
  import fib_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int FIB_W = 24
) ();

  // Handshake: start is a request that is accepted only while the codec is idle
  // (busy=0, done=0) and is never queued; mode/bin_in/fib_in are sampled with it.
  // done is a one-cycle result-valid with no back-pressure; results hold until the next done.
  logic             start;
  logic             mode;
  logic [BIN_W-1:0] bin_in;
  logic [FIB_W-1:0] fib_in;
  logic             busy;
  logic             done;
  logic [FIB_W-1:0] fib_out;
  logic [BIN_W-1:0] bin_out;
  logic             nonstd;
  logic             ovf;
  state_t           state;

  modport master (
    output start, mode, bin_in, fib_in,
    input  busy, done, fib_out, bin_out, nonstd, ovf, state
  );

  modport slave (
    input  start, mode, bin_in, fib_in,
    output busy, done, fib_out, bin_out, nonstd, ovf, state
  );

endinterface

// File: rtl/fib_weight_gen.sv
// Descending Fibonacci weight walker: holds (F(k+2), F(k+3)) and steps to (b-a, a)
// so the current digit weight is produced without any table.
module fib_weight_gen
  import fib_pkg::*;
#(
  parameter int            WW   = FIB_W_DEF + 1,
  parameter logic [WW-1:0] TOP  = WW'(FIB_TOP),
  parameter logic [WW-1:0] NEXT = WW'(FIB_NEXT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  output logic [WW-1:0] weight
);

  logic [WW-1:0] a_q;
  logic [WW-1:0] b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= TOP;
      b_q <= NEXT;
    end else if (step) begin
      a_q <= b_q - a_q;
      b_q <= a_q;
    end
  end

  assign weight = a_q;

endmodule

// File: rtl/binary_fibonacci_codec.sv
// Serial binary <-> Zeckendorf codec, one Fibonacci digit per cycle, MSB digit first.
// Decode path (mode, nonstd, ovf) is built only when FIB_DECODE_EN is defined.
module binary_fibonacci_codec
  import fib_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int FIB_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  binary_fibonacci_codec_if.slave  bus
);

  localparam int            WW      = FIB_W + 1;
  localparam int            SW      = ((WW > BIN_W) ? WW : BIN_W) + 1;
  localparam int            IW      = $clog2(FIB_W + 1);
  localparam logic [WW-1:0] W_TOP   = WW'(fib_top(FIB_W));
  localparam logic [WW-1:0] W_NEXT  = WW'(fib_next(FIB_W));
  localparam logic [63:0]   BIN_MAX = (64'd1 << BIN_W) - 64'd1;

  // FIB_W digits span 0..F(FIB_W+2)-1, which must cover every BIN_W-bit operand.
  if (fib(FIB_W + 2) <= BIN_MAX) begin : g_range_check
    $error("FIB_W too small to represent every BIN_W-bit value");
  end

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    idx_q;
  logic [BIN_W-1:0] rem_q;
  logic [FIB_W-1:0] dig_q;
  logic [FIB_W-1:0] fib_out_q;

  logic             accept;
  logic             last;
  logic             dec;
  logic             take;
  logic [WW-1:0]    weight;
  logic [SW-1:0]    w_ext;
  logic [SW-1:0]    rem_ext;
  logic [BIN_W-1:0] rem_nxt;
  logic [FIB_W-1:0] dig_nxt;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (state_q == RUN) && (idx_q == '0);

  fib_weight_gen #(
    .WW   (WW),
    .TOP  (W_TOP),
    .NEXT (W_NEXT)
  ) u_weight (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state_q == RUN),
    .weight (weight)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (idx_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.state = state_q;
    case (state_q)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- decode path
`ifdef FIB_DECODE_EN
  logic             mode_q;
  logic             nonstd_q;
  logic [BIN_W:0]   acc_q;
  logic [BIN_W:0]   acc_nxt;
  logic [SW-1:0]    sum;
  logic [BIN_W-1:0] bin_out_q;
  logic             nonstd_out_q;
  logic             ovf_q;

  assign dec = mode_q;

  // acc_q[BIN_W] is a sticky carry: once any partial sum overflows it stays set.
  always_comb begin
    sum     = SW'(acc_q[BIN_W-1:0]) + w_ext;
    acc_nxt = acc_q;
    if (dig_q[FIB_W-1]) acc_nxt = {acc_q[BIN_W] | (|sum[SW-1:BIN_W]), sum[BIN_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= 1'b0;
      nonstd_q     <= 1'b0;
      acc_q        <= '0;
      bin_out_q    <= '0;
      nonstd_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (accept) begin
        mode_q   <= bus.mode;
        nonstd_q <= |(bus.fib_in & (bus.fib_in >> 1));
        acc_q    <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_nxt;
      end
      if (last) begin
        bin_out_q    <= dec ? acc_nxt[BIN_W-1:0] : '0;
        nonstd_out_q <= dec & nonstd_q;
        ovf_q        <= dec & acc_nxt[BIN_W];
      end
    end
  end

  assign bus.bin_out = bin_out_q;
  assign bus.nonstd  = nonstd_out_q;
  assign bus.ovf     = ovf_q;
`else
  logic unused_dec;

  assign dec         = 1'b0;
  assign unused_dec  = ^{bus.mode, bus.fib_in};
  assign bus.bin_out = '0;
  assign bus.nonstd  = 1'b0;
  assign bus.ovf     = 1'b0;
`endif

  // ---------------------------------------------------------------- digit datapath
  // dig_q is shared: decode shifts the operand out of the MSB, encode shifts result digits in at the LSB.
  always_comb begin
    w_ext   = SW'(weight);
    rem_ext = SW'(rem_q);
    take    = (rem_ext >= w_ext) && !dec;
    rem_nxt = take ? BIN_W'(rem_ext - w_ext) : rem_q;
    dig_nxt = (dig_q << 1) | FIB_W'(take);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      rem_q     <= '0;
      dig_q     <= '0;
      fib_out_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= IW'(FIB_W - 1);
        rem_q <= bus.bin_in;
`ifdef FIB_DECODE_EN
        dig_q <= bus.mode ? bus.fib_in : '0;
`else
        dig_q <= '0;
`endif
      end else if (state_q == RUN) begin
        idx_q <= idx_q - IW'(1);
        rem_q <= rem_nxt;
        dig_q <= dig_nxt;
      end
      if (last) fib_out_q <= dec ? '0 : dig_nxt;
    end
  end

  assign bus.fib_out = fib_out_q;

endmodule
